// File: rtl/vec_pkg.sv
// Shared types and defaults for the serial-to-parallel vector assembler.
package vec_pkg;

   localparam int DATA_WIDTH_IN_DEF = 16;
   localparam int N_IN_DEF          = 8;
   localparam int CNT_WIDTH_DEF     = 16;

   typedef logic [DATA_WIDTH_IN_DEF-1:0] lane_t;
   typedef lane_t vec_t [N_IN_DEF];

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

endpackage

// File: rtl/vec_out_slice.sv
// Output register for the assembled vector: holds data/pad stable until the
// consumer takes it, and counts completed handoffs.
module vec_out_slice
   import vec_pkg::*;
#(
   parameter int DATA_WIDTH_IN = DATA_WIDTH_IN_DEF,
   parameter int N_IN          = N_IN_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     load_i,
   input  logic [DATA_WIDTH_IN-1:0] load_data_i [N_IN],
   input  logic                     load_pad_i,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [DATA_WIDTH_IN-1:0] o_data [N_IN],
   output logic                     o_pad,
   output logic [CNT_WIDTH-1:0]     o_vec_cnt,
   output logic                     o_slot_free
);

   logic                     valid_q;
   logic                     pad_q;
   logic [DATA_WIDTH_IN-1:0] data_q [N_IN];
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic                     handoff;

   assign handoff     = valid_q && i_ready;
   assign o_slot_free = !valid_q || i_ready;
   assign cnt_d       = handoff ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         pad_q   <= 1'b0;
         cnt_q   <= '0;
         for (int j = 0; j < N_IN; j++) data_q[j] <= '0;
      end else begin
         cnt_q <= cnt_d;
         // A load in the same cycle as a handoff keeps valid high: no bubble.
         if (load_i) begin
            valid_q <= 1'b1;
            pad_q   <= load_pad_i;
            data_q  <= load_data_i;
         end else if (handoff) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_valid   = valid_q;
   assign o_pad     = pad_q;
   assign o_data    = data_q;
   assign o_vec_cnt = cnt_q;

endmodule

// File: rtl/vec_assembler.sv
// Packs N_IN serial samples into a lane vector; fill buffer plus output
// register give two-deep buffering so collection overlaps a stalled output.
module vec_assembler
   import vec_pkg::*;
#(
   parameter int DATA_WIDTH_IN = DATA_WIDTH_IN_DEF,
   parameter int N_IN          = N_IN_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic [DATA_WIDTH_IN-1:0] i_data,
   input  logic                     i_last,
   output logic                     o_ready,
   output logic [DATA_WIDTH_IN-1:0] o_data [N_IN],
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic                     o_pad,
   output logic [CNT_WIDTH-1:0]     o_vec_cnt
);

   localparam int IW = $clog2(N_IN);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

   state_e                   state_q, state_d;
   logic [IW-1:0]            wr_idx_q, wr_idx_d;
   logic [DATA_WIDTH_IN-1:0] fill_q [N_IN];
   logic [DATA_WIDTH_IN-1:0] fill_d [N_IN];
   logic                     hpad_q, hpad_d;
   logic [DATA_WIDTH_IN-1:0] vec_now [N_IN];
   logic [DATA_WIDTH_IN-1:0] load_data [N_IN];
   logic                     load, load_pad, slot_free;
   logic                     beat, complete, pad_now;

   assign o_ready  = (state_q == FILL);
   assign beat     = i_valid && o_ready;
   assign complete = beat && (wr_idx_q == LAST_IDX || i_last);
   assign pad_now  = i_last && (wr_idx_q != LAST_IDX);

   always_comb begin
      state_d   = state_q;
      wr_idx_d  = wr_idx_q;
      fill_d    = fill_q;
      hpad_d    = hpad_q;
      load      = 1'b0;
      load_pad  = 1'b0;
      // Current beat merged into the buffer, lanes above it forced to zero.
      for (int j = 0; j < N_IN; j++) begin
         if (IW'(j) < wr_idx_q)       vec_now[j] = fill_q[j];
         else if (IW'(j) == wr_idx_q) vec_now[j] = i_data;
         else                         vec_now[j] = '0;
      end
      load_data = vec_now;

      case (state_q)
         FILL: begin
            if (complete) begin
               if (slot_free) begin
                  load     = 1'b1;
                  load_pad = pad_now;
                  wr_idx_d = '0;
                  for (int j = 0; j < N_IN; j++) fill_d[j] = '0;
               end else begin
                  fill_d  = vec_now;
                  hpad_d  = pad_now;
                  state_d = HOLD;
               end
            end else if (beat) begin
               fill_d[wr_idx_q] = i_data;
               wr_idx_d         = wr_idx_q + 1'b1;
            end
         end
         HOLD: begin
            // Output is necessarily valid here, so i_ready alone means handoff.
            if (o_valid && i_ready) begin
               load      = 1'b1;
               load_data = fill_q;
               load_pad  = hpad_q;
               wr_idx_d  = '0;
               hpad_d    = 1'b0;
               for (int j = 0; j < N_IN; j++) fill_d[j] = '0;
               state_d   = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= FILL;
         wr_idx_q <= '0;
         hpad_q   <= 1'b0;
         for (int j = 0; j < N_IN; j++) fill_q[j] <= '0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         hpad_q   <= hpad_d;
         fill_q   <= fill_d;
      end
   end

   vec_out_slice #(
      .DATA_WIDTH_IN (DATA_WIDTH_IN),
      .N_IN          (N_IN),
      .CNT_WIDTH     (CNT_WIDTH)
   ) u_out (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .load_i      (load),
      .load_data_i (load_data),
      .load_pad_i  (load_pad),
      .i_ready     (i_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_pad       (o_pad),
      .o_vec_cnt   (o_vec_cnt),
      .o_slot_free (slot_free)
   );

endmodule

// File: tb/tb_vec_assembler.sv
// Scoreboard bench for vec_assembler: a queue-based packing model predicts
// every vector; a monitor pops and compares on each output handoff.
module tb_vec_assembler;

   localparam int W  = 16;
   localparam int N  = 8;
   localparam int CW = 4;
   localparam int VW = W * N;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_valid;
   logic [W-1:0]  i_data;
   logic          i_last;
   logic          i_ready;
   logic          o_ready;
   logic [W-1:0]  o_data [N];
   logic          o_valid;
   logic          o_pad;
   logic [CW-1:0] o_vec_cnt;

   always #5 i_clk = ~i_clk;

   vec_assembler #(.DATA_WIDTH_IN(W), .N_IN(N), .CNT_WIDTH(CW)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_last    (i_last),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_pad     (o_pad),
      .o_vec_cnt (o_vec_cnt)
   );

   logic [VW-1:0] exp_q[$];
   logic          exp_pad_q[$];
   logic [W-1:0]  part_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;
   int            stall_cnt = 0;
   int            cnt_model = 0;
   logic          rdy_cfg = 1'b1;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [VW-1:0] pack_out();
      logic [VW-1:0] v;
      for (int j = 0; j < N; j++) v[j*W +: W] = o_data[j];
      return v;
   endfunction

   function automatic logic [VW-1:0] vec_of(input int base);
      logic [VW-1:0] v;
      for (int j = 0; j < N; j++) v[j*W +: W] = W'(base + j);
      return v;
   endfunction

   // Reference: collect samples; a vector closes at N samples or on last.
   task automatic model_accept(input logic [W-1:0] d, input logic last);
      logic [VW-1:0] v;
      part_q.push_back(d);
      if (part_q.size() == N || last) begin
         v = '0;
         foreach (part_q[j]) v[j*W +: W] = part_q[j];
         exp_q.push_back(v);
         exp_pad_q.push_back(part_q.size() < N);
         part_q.delete();
      end
   endtask

   task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic l, output bit acc);
      @(negedge i_clk);
      i_valid = v;
      i_data  = d;
      i_last  = l;
      i_ready = rdy_cfg;
      acc = v && o_ready;
      if (v && !o_ready) stall_cnt++;
      @(posedge i_clk);
      if (acc) model_accept(d, l);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, 1'b0, acc);
   endtask

   task automatic send_beat(input logic [W-1:0] d, input logic l);
      bit acc;
      int tries;
      tries = 0;
      do begin
         drive_cycle(1'b1, d, l, acc);
         tries++;
      end while (!acc && tries < 200);
      if (!acc) check("send_timeout", VW'(0), VW'(1));
   endtask

   // Monitor: a handoff happens at the next rising edge when valid && ready.
   initial begin
      forever begin
         @(negedge i_clk);
         #1;
         if (!i_rst_n) begin
            cnt_model = 0;
         end else if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_vec", VW'(1), VW'(0));
            end else begin
               check("vec_data", pack_out(), exp_q.pop_front());
               check("vec_pad", VW'(o_pad), VW'(exp_pad_q.pop_front()));
               check("vec_cnt", VW'(o_vec_cnt), VW'(cnt_model));
            end
            cnt_model = (cnt_model + 1) % (1 << CW);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VW-1:0] v;
      int            cnt0, guard;
      bit            acc;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_last  = 1'b0;
      i_ready = 1'b1;
      #12;
      check("rst_valid", VW'(o_valid), VW'(0));
      check("rst_ready", VW'(o_ready), VW'(1));
      check("rst_pad", VW'(o_pad), VW'(0));
      check("rst_cnt", VW'(o_vec_cnt), VW'(0));
      check("rst_data", pack_out(), VW'(0));
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Full vector 1..8, one-cycle latency.
      for (int k = 1; k <= 8; k++) send_beat(W'(k), 1'b0);
      #1;
      check("t1_latency_valid", VW'(o_valid), VW'(1));
      check("t1_data", pack_out(), vec_of(1));
      check("t1_pad", VW'(o_pad), VW'(0));
      idle(1);
      #1;
      check("t1_cnt", VW'(o_vec_cnt), VW'(1));

      // Short burst ending with last: zero padding.
      send_beat(16'hAAAA, 1'b0);
      send_beat(16'hBBBB, 1'b0);
      send_beat(16'hCCCC, 1'b1);
      #1;
      v = '0;
      v[0 +: W] = 16'hAAAA;
      v[W +: W] = 16'hBBBB;
      v[2*W +: W] = 16'hCCCC;
      check("t2_data", pack_out(), v);
      check("t2_pad", VW'(o_pad), VW'(1));
      idle(2);

      // Output stalled: second vector held in the fill buffer.
      rdy_cfg = 1'b0;
      for (int k = 0; k < 16; k++) send_beat(W'(101 + k), 1'b0);
      #1;
      check("t3_hold_ready", VW'(o_ready), VW'(0));
      check("t3_hold_data", pack_out(), vec_of(101));
      idle(3);
      #1;
      check("t3_stable_data", pack_out(), vec_of(101));
      check("t3_stable_ready", VW'(o_ready), VW'(0));
      rdy_cfg = 1'b1;
      idle(1);
      rdy_cfg = 1'b0;
      #1;
      check("t3_second_valid", VW'(o_valid), VW'(1));
      check("t3_second_data", pack_out(), vec_of(109));
      check("t3_ready_back", VW'(o_ready), VW'(1));
      rdy_cfg = 1'b1;
      idle(2);

      // Continuous stream with ready high: no stalls.
      cnt0 = int'(o_vec_cnt);
      stall_cnt = 0;
      for (int k = 0; k < 24; k++) send_beat(W'($urandom), 1'b0);
      idle(1);
      #1;
      check("t4_no_stall", VW'(stall_cnt), VW'(0));
      check("t4_cnt", VW'(o_vec_cnt), VW'((cnt0 + 3) % (1 << CW)));

      // Asynchronous reset mid-cycle after a partial fill.
      for (int k = 0; k < 5; k++) send_beat(W'(200 + k), 1'b0);
      #2;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      #1;
      check("t5_rst_valid", VW'(o_valid), VW'(0));
      check("t5_rst_cnt", VW'(o_vec_cnt), VW'(0));
      check("t5_rst_data", pack_out(), VW'(0));
      check("t5_rst_ready", VW'(o_ready), VW'(1));
      part_q.delete();
      exp_q.delete();
      exp_pad_q.delete();
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int k = 9; k <= 16; k++) send_beat(W'(k), 1'b0);
      #1;
      check("t5_new_data", pack_out(), vec_of(9));
      check("t5_new_pad", VW'(o_pad), VW'(0));
      idle(2);
      #1;
      check("t5_cnt", VW'(o_vec_cnt), VW'(1));

      // Random traffic with random backpressure and bursts.
      for (int k = 0; k < 400; k++) begin
         rdy_cfg = 1'($urandom_range(0, 1));
         drive_cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) == 0, acc);
      end
      rdy_cfg = 1'b1;
      if (part_q.size() != 0) send_beat(W'($urandom), 1'b1);
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         idle(1);
         guard++;
      end
      idle(1);
      check("t6_drain", VW'(exp_q.size()), VW'(0));

      // Counter wrap: step up to all-ones, then one more handoff.
      guard = 0;
      #1;
      while (o_vec_cnt != CW'((1 << CW) - 1) && guard < 40) begin
         send_beat(W'($urandom), 1'b1);
         idle(1);
         #1;
         guard++;
      end
      check("t7_cnt_max", VW'(o_vec_cnt), VW'((1 << CW) - 1));
      send_beat(16'h1234, 1'b1);
      idle(1);
      #1;
      check("t7_cnt_wrap", VW'(o_vec_cnt), VW'(0));
      idle(2);
      check("final_queue_empty", VW'(exp_q.size()), VW'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
